fir_coeff_loader: RTL

//  Writer side of the FIR filter coefficient interface.
//  - Receives NUM_TAPS coefficients as a serial valid/ready stream into a shadow bank.
//  - Commits the whole shadow bank to the active bank in one step, so the filter never sees a half-updated set.
//  - coeff_flat feeds the filter's coeff input directly.

---
 rtl/fir_coeff_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fir_coeff_loader.sv
// Writer side of the FIR coefficient interface: serial load into a shadow bank, atomic commit to the active bank.
// Optional checksum beat after the coefficients is enabled by defining COEFF_CHECKSUM_EN.
module fir_coeff_loader #(
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            cin_valid,
  output logic                            cin_ready,
  input  logic [COEFF_WIDTH-1:0]          cin_data,
  input  logic                            cin_last,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff_flat,
  output logic                            coeff_update,
  output logic                            busy,
  output logic                            err
);

  localparam int IDX_WIDTH = $clog2(NUM_TAPS) + 1;
  localparam int TAP_AW    = $clog2(NUM_TAPS);

`ifdef COEFF_CHECKSUM_EN
  localparam logic [IDX_WIDTH-1:0] TERM_IDX = IDX_WIDTH'(NUM_TAPS);
`else
  localparam logic [IDX_WIDTH-1:0] TERM_IDX = IDX_WIDTH'(NUM_TAPS - 1);
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]                            state;
  logic [IDX_WIDTH-1:0]                  idx;
  logic [COEFF_WIDTH-1:0]                shadow [NUM_TAPS];
  logic [NUM_TAPS*COEFF_WIDTH-1:0]       shadow_flat;
  logic [NUM_TAPS*COEFF_WIDTH-1:0]       active;
  logic [TAP_AW-1:0]                     tap_sel;
  logic                                  hs;
  logic                                  is_term;
`ifdef COEFF_CHECKSUM_EN
  logic [COEFF_WIDTH-1:0]                sum;
`endif

  assign cin_ready  = (state == ST_LOAD);
  assign hs         = cin_valid && cin_ready;
  assign is_term    = (idx == TERM_IDX);
  assign tap_sel    = idx[TAP_AW-1:0];
  assign coeff_flat = active;

  always_comb begin
    shadow_flat = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      shadow_flat[k*COEFF_WIDTH +: COEFF_WIDTH] = shadow[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      active       <= '0;
      coeff_update <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow[k] <= '0;
      end
`ifdef COEFF_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      coeff_update <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD;
            idx   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
`ifdef COEFF_CHECKSUM_EN
            sum   <= '0;
`endif
          end
        end

        ST_LOAD: begin
          if (hs) begin
            if (is_term) begin
`ifdef COEFF_CHECKSUM_EN
              // Terminal beat carries the checksum; it is never stored as a tap.
              if (cin_last && (cin_data == sum)) begin
                state <= ST_COMMIT;
              end else begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
`else
              shadow[tap_sel] <= cin_data;
              if (cin_last) begin
                state <= ST_COMMIT;
              end else begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
`endif
            end else if (cin_last) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              shadow[tap_sel] <= cin_data;
              idx             <= idx + 1'b1;
`ifdef COEFF_CHECKSUM_EN
              sum             <= sum + cin_data;
`endif
            end
          end
        end

        ST_COMMIT: begin
          active       <= shadow_flat;
          coeff_update <= 1'b1;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
